// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: state encoding and default parameters shared by mult_arbiter
package mult_arb_pkg;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_TIMEOUT = 72;
   typedef enum logic [1:0] {IDLE, START, WAIT, DELIVER} state_t;
endpackage

// File: rtl/mult_arbiter_if.sv
// mult_arbiter_if: requester and multiplier signals of mult_arbiter; slave is the arbiter side
interface mult_arbiter_if import mult_arb_pkg::*; #(parameter int WIDTH = DEF_WIDTH);
   logic [1:0] req;
   logic [WIDTH-1:0] a0, b0, a1, b1;
   logic [1:0] gnt, ack;
   logic [2*WIDTH-1:0] result;
   logic busy, mul_st, mul_done, err;
   logic [WIDTH-1:0] mul_a, mul_b;
   logic [2*WIDTH-1:0] mul_p;
   modport master (
      output req, a0, b0, a1, b1, mul_done, mul_p,
      input gnt, ack, result, busy, mul_st, mul_a, mul_b, err
   );
   modport slave (
      input req, a0, b0, a1, b1, mul_done, mul_p,
      output gnt, ack, result, busy, mul_st, mul_a, mul_b, err
   );
endinterface

// File: rtl/mult_arb_rr.sv
// mult_arb_rr: two-way round-robin picker; a sole requester wins, a tie goes to the one not granted last
module mult_arb_rr (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] win
);
   assign win = (req == 2'b11) ? (last ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: shares one shift-add multiplier between two requesters; MULT_ARB_TIMEOUT_EN adds a WAIT watchdog
module mult_arbiter import mult_arb_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input logic Clk,
   input logic reset,
   mult_arbiter_if.slave bus
);
   state_t st, nxt;
   logic [1:0] win, win_q;
   logic last, mul_st_q, tmo, err_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [2*WIDTH-1:0] res_q;

   mult_arb_rr u_rr (.req(bus.req), .last(last), .win(win));

   // state register
   always_ff @(posedge Clk or posedge reset)
      if (reset) st <= IDLE;
      else st <= nxt;

   // next-state logic
   always_comb begin
      nxt = st;
      case (st)
         IDLE:    nxt = |bus.req ? START : IDLE;
         START:   nxt = WAIT;
         WAIT:    nxt = bus.mul_done ? DELIVER : (tmo ? IDLE : WAIT);
         DELIVER: nxt = IDLE;
      endcase
   end

   // winner/operand capture on grant, start pulse on leaving START, product capture in WAIT
   always_ff @(posedge Clk or posedge reset)
      if (reset) begin
         win_q <= 2'b00;
         last <= 1'b1;
         a_q <= '0;
         b_q <= '0;
         res_q <= '0;
         mul_st_q <= 1'b0;
      end else begin
         mul_st_q <= st == START;
         if (st == IDLE && |bus.req) begin
            win_q <= win;
            last <= win[1];
            a_q <= win[1] ? bus.a1 : bus.a0;
            b_q <= win[1] ? bus.b1 : bus.b0;
         end
         if (st == WAIT && bus.mul_done) res_q <= bus.mul_p;
      end

`ifdef MULT_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt;
   assign tmo = st == WAIT && !bus.mul_done && cnt == CW'(TIMEOUT - 1);

   // watchdog: cleared in START, counts WAIT cycles; err stays set until reset
   always_ff @(posedge Clk or posedge reset)
      if (reset) begin
         cnt <= '0;
         err_q <= 1'b0;
      end else begin
         cnt <= st == START ? '0 : (st == WAIT ? cnt + 1'b1 : cnt);
         if (tmo) err_q <= 1'b1;
      end
`else
   logic unused_timeout;
   assign unused_timeout = |TIMEOUT;
   assign tmo = 1'b0;
   assign err_q = 1'b0;
`endif

   assign bus.gnt = st == START ? win_q : 2'b00;
   assign bus.ack = st == DELIVER ? win_q : 2'b00;
   assign bus.busy = st != IDLE;
   assign bus.mul_st = mul_st_q;
   assign bus.mul_a = a_q;
   assign bus.mul_b = b_q;
   assign bus.result = res_q;
   assign bus.err = err_q;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed table-driven bench for mult_arbiter with an inline multiplier model
module tb_mult_arbiter;
   import mult_arb_pkg::*;
   logic Clk = 1'b0;
   logic reset = 1'b1;
   int errors = 0;
   int checks = 0;

   mult_arbiter_if #(.WIDTH(16)) bus();
   mult_arbiter #(.WIDTH(16), .TIMEOUT(DEF_TIMEOUT)) dut (.Clk(Clk), .reset(reset), .bus(bus));

   always #5 Clk = ~Clk;

   typedef struct {
      bit rst_first;
      logic [1:0] req;
      logic [15:0] a0, b0, a1, b1;
      int lat;
      bit drop;
      logic [1:0] gnt;
      logic [31:0] res;
   } vec_t;
   vec_t v[11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.req = 2'b00;
      bus.mul_done = 1'b0;
      bus.mul_p = '0;
      repeat (2) @(negedge Clk);
      reset = 1'b0;
   endtask

   task automatic run(input vec_t t);
      logic [15:0] ea, eb;
      ea = t.gnt[1] ? t.a1 : t.a0;
      eb = t.gnt[1] ? t.b1 : t.b0;
      bus.req = t.req;
      bus.a0 = t.a0;
      bus.b0 = t.b0;
      bus.a1 = t.a1;
      bus.b1 = t.b1;
      @(negedge Clk);
      chk("gnt", bus.gnt, t.gnt);
      chk("start_busy_mulst_ack", {bus.busy, bus.mul_st, bus.ack}, 4'b1000);
      chk("mul_a", bus.mul_a, ea);
      chk("mul_b", bus.mul_b, eb);
      if (t.drop) bus.req = 2'b00;
      @(negedge Clk);
      chk("mul_st_pulse_gnt", {bus.mul_st, bus.gnt}, 3'b100);
      for (int i = 0; i < t.lat; i++) begin
         @(negedge Clk);
         chk("wait_mulst_ack_busy", {bus.mul_st, bus.ack, bus.busy}, 4'b0001);
      end
      bus.mul_done = 1'b1;
      bus.mul_p = bus.mul_a * bus.mul_b;
      @(negedge Clk);
      bus.mul_done = 1'b0;
      bus.mul_p = 32'hDEADBEEF;
      chk("ack", bus.ack, t.gnt);
      chk("result", bus.result, t.res);
      @(negedge Clk);
      chk("idle_ack_busy_gnt", {bus.ack, bus.busy, bus.gnt}, 5'b0);
      chk("result_hold", bus.result, t.res);
   endtask

   initial begin
      bit ack_seen;
      bus.req = 2'b00;
      bus.a0 = '0;
      bus.b0 = '0;
      bus.a1 = '0;
      bus.b1 = '0;
      bus.mul_done = 1'b0;
      bus.mul_p = '0;
      v[0]  = '{0, 2'b11, 16'd3, 16'd5, 16'd16, 16'd32, 2, 0, 2'b01, 32'd15};
      v[1]  = '{0, 2'b11, 16'd3, 16'd5, 16'd16, 16'd32, 1, 0, 2'b10, 32'd512};
      v[2]  = '{0, 2'b11, 16'd1234, 16'd10, 16'd16, 16'd32, 3, 0, 2'b01, 32'd12340};
      v[3]  = '{0, 2'b11, 16'd1234, 16'd10, 16'hFFFF, 16'hFFFF, 0, 0, 2'b10, 32'hFFFE0001};
      v[4]  = '{1, 2'b01, 16'd3, 16'd5, 16'd0, 16'd0, 2, 0, 2'b01, 32'd15};
      v[5]  = '{0, 2'b01, 16'd0, 16'hFFFF, 16'd0, 16'd0, 1, 0, 2'b01, 32'd0};
      v[6]  = '{0, 2'b10, 16'd0, 16'd0, 16'd2, 16'd3, 4, 0, 2'b10, 32'd6};
      v[7]  = '{0, 2'b10, 16'd0, 16'd0, 16'hFFFF, 16'd1, 0, 0, 2'b10, 32'h0000FFFF};
      v[8]  = '{0, 2'b11, 16'hFFFF, 16'hFFFF, 16'd9, 16'd9, 1, 0, 2'b01, 32'hFFFE0001};
      v[9]  = '{0, 2'b01, 16'd12, 16'd12, 16'd0, 16'd0, 2, 1, 2'b01, 32'd144};
      v[10] = '{0, 2'b11, 16'd0, 16'd0, 16'd5, 16'd7, 1, 0, 2'b10, 32'd35};

      repeat (2) @(negedge Clk);
      chk("reset_ctrl", {bus.gnt, bus.ack, bus.busy, bus.mul_st, bus.err}, 7'b0);
      chk("reset_data", {bus.result, bus.mul_a, bus.mul_b}, 64'b0);
      reset = 1'b0;

      foreach (v[i]) begin
         if (v[i].rst_first) do_reset();
         run(v[i]);
      end

      bus.req = 2'b00;
      bus.mul_done = 1'b1;
      bus.mul_p = 32'd999;
      @(negedge Clk);
      bus.mul_done = 1'b0;
      chk("stray_done_busy_ack", {bus.busy, bus.ack}, 3'b0);
      chk("stray_done_result", bus.result, 32'd35);

      bus.req = 2'b01;
      bus.a0 = 16'd6;
      bus.b0 = 16'd7;
      @(negedge Clk);
      bus.req = 2'b00;
      @(negedge Clk);
      @(negedge Clk);
      reset = 1'b1;
      #1;
      chk("abort_ctrl", {bus.gnt, bus.ack, bus.busy, bus.mul_st, bus.err}, 7'b0);
      chk("abort_data", {bus.result, bus.mul_a, bus.mul_b}, 64'b0);
      @(negedge Clk);
      reset = 1'b0;
      @(negedge Clk);
      bus.mul_done = 1'b1;
      bus.mul_p = 32'd42;
      @(negedge Clk);
      bus.mul_done = 1'b0;
      chk("late_done_ctrl", {bus.gnt, bus.ack, bus.busy, bus.mul_st}, 6'b0);
      chk("late_done_result", bus.result, 32'd0);
      @(negedge Clk);
      chk("late_done_after", {bus.ack, bus.busy}, 3'b0);

`ifdef MULT_ARB_TIMEOUT_EN
      bus.req = 2'b01;
      bus.a0 = 16'd2;
      bus.b0 = 16'd2;
      @(negedge Clk);
      bus.req = 2'b00;
      @(negedge Clk);
      ack_seen = 1'b0;
      for (int k = 1; k <= DEF_TIMEOUT; k++) begin
         @(negedge Clk);
         if (bus.ack != 2'b00) ack_seen = 1'b1;
         if (k == DEF_TIMEOUT - 1) chk("err_before_timeout", {bus.err, bus.busy}, 2'b01);
         if (k == DEF_TIMEOUT) chk("err_at_timeout", {bus.err, bus.busy}, 2'b10);
      end
      chk("timeout_no_ack", ack_seen, 1'b0);
      run('{0, 2'b10, 16'd0, 16'd0, 16'd4, 16'd4, 1, 0, 2'b10, 32'd16});
      chk("err_sticky", bus.err, 1'b1);
`else
      ack_seen = 1'b0;
      chk("err_tied_low", {ack_seen, bus.err}, 2'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: operand width; product width is 2*WIDTH.
REQ-002 Parameter TIMEOUT, default 72: cycles allowed between mul_st and mul_done (used only with MULT_ARB_TIMEOUT_EN).
REQ-003 Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req  input  2  per-requester request; bit i belongs to requester i.
REQ-006 a0, b0 / a1, b1  input  WIDTH each  operands of requester 0 / requester 1.
REQ-007 gnt  output  2  one-hot; bit i high for one cycle when requester i's operands are captured.
REQ-008 ack  output  2  one-hot; bit i high for one cycle when result is valid for requester i.
REQ-009 result  output  2*WIDTH  product; valid only in the ack cycle.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 mul_st  output  1  one-cycle start pulse to the shared shift-add multiplier.
REQ-012 mul_a, mul_b  output  WIDTH each  registered operands driven to the multiplier.
REQ-013 mul_done  input  1  multiplier completion; mul_p is valid while it is high.
REQ-014 mul_p  input  2*WIDTH  multiplier product.
REQ-015 err  output  1  sticky timeout flag (tied 0 without MULT_ARB_TIMEOUT_EN).

Function
REQ-016 The FSM SHALL have states IDLE, START, WAIT and DELIVER.
REQ-017 IDLE: if any req bit is high, pick a winner, assert gnt[win], capture its operands into mul_a/mul_b, go to START; else stay.
REQ-018 Arbitration: round-robin; a sole requester always wins; if both request, the requester not granted last wins; after reset requester 0 has priority.
REQ-019 START: mul_st=1 for exactly one cycle, then go to WAIT.
REQ-020 WAIT: on mul_done=1, capture mul_p into result, go to DELIVER; otherwise stay.
REQ-021 DELIVER: ack[win]=1 for one cycle with result stable, then go to IDLE.
REQ-022 Latency: req sampled high in IDLE at edge N gives mul_st high after edge N+1, and ack follows one cycle after the edge that samples mul_done.
REQ-023 Minimum request-to-request spacing is one IDLE cycle; back-to-back service of both requesters alternates.
REQ-024 A granted operation SHALL complete and ack SHALL pulse even if req drops after gnt.
REQ-025 req changes while busy are ignored until the next IDLE.
REQ-026 mul_done outside WAIT is ignored.
REQ-027 mul_a, mul_b and result SHALL hold their values until overwritten.

Reset
REQ-028 While reset=1: state=IDLE, gnt=0, ack=0, mul_st=0, busy=0, err=0, result=0, mul_a=mul_b=0, last-grant pointer set to requester 1 so that requester 0 wins first.
REQ-029 Reset during START/WAIT/DELIVER aborts the operation with no ack; a late mul_done after reset is ignored.

Configuration
REQ-030 Macro MULT_ARB_TIMEOUT_EN defined: a counter is cleared at START and counts in WAIT; reaching TIMEOUT without mul_done sets err, returns to IDLE and issues no ack; err clears only on reset.
REQ-031 Macro undefined: no counter; WAIT waits indefinitely; err is constant 0.

Structure
REQ-032 Package mult_arb_pkg SHALL hold the state encoding, the default WIDTH and the default TIMEOUT.
REQ-033 The two-way round-robin picker SHALL be the sub-module mult_arb_rr (inputs req and last-grant pointer, output one-hot winner).

Verification
REQ-034 Reset, req=01, a0=3, b0=5, model returns mul_p=15 -> gnt=01, mul_st one pulse, ack=01 with result=15, busy back to 0.
REQ-035 req=11 held continuously after reset -> grants in order 01,10,01,10; each ack matches its requester's operands.
REQ-036 a1=16'hFFFF, b1=16'hFFFF -> result=32'hFFFE0001 on ack=10.
REQ-037 reset asserted in WAIT, mul_done pulsed two cycles later -> no ack, state IDLE, all outputs 0.
REQ-038 With MULT_ARB_TIMEOUT_EN defined, mul_done never asserted -> err=1 exactly TIMEOUT cycles after entering WAIT, no ack, a new req is then served.
REQ-039 req=01 dropped the cycle after gnt -> ack=01 still issued with the correct product.
